// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC and drives a single-outstanding
// request/response instruction bus, presenting one instruction at a time to IF_ID.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  logic        branch_flag,
  input  logic [31:0] branch_target,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        stallreq_if
);

  // state  | meaning
  // S_IDLE | just out of reset, nothing requested yet
  // S_REQ  | request for pc on the bus, waiting for addr_ok
  // S_WAIT | request accepted, waiting for data_ok (cancel_q drops the data)
  // S_DONE | instruction held in inst_buf and presented to IF_ID
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_buf_q, inst_buf_d;
  logic [31:0] br_target_q, br_target_d;
  logic        br_pend_q, br_pend_d;
  logic        cancel_q, cancel_d;
  logic        advance;

  // Only the PC-hold bit of the stall vector matters to this stage.
  logic unused_stall;
  assign unused_stall = ^stall[5:1];

  assign advance = (state_q == S_DONE) && !stall[0] && !flush;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    inst_buf_d  = inst_buf_q;
    br_target_d = br_target_q;
    br_pend_d   = br_pend_q;
    cancel_d    = cancel_q;

    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (inst_addr_ok) begin
          state_d = S_WAIT;
          if (flush) cancel_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (inst_data_ok) begin
          if (cancel_q || flush) begin
            state_d  = S_REQ;
            cancel_d = 1'b0;
          end else begin
            inst_buf_d = inst_rdata;
            state_d    = S_DONE;
          end
        end else if (flush) begin
          cancel_d = 1'b1;
        end
      end
      S_DONE: begin
        if (flush || !stall[0]) state_d = S_REQ;
      end
      default: state_d = S_IDLE;
    endcase

    // A branch never disturbs the fetch in flight; it is applied when the
    // current (delay slot) instruction leaves S_DONE.
    if (flush) begin
      pc_d      = flush_pc;
      br_pend_d = 1'b0;
    end else if (advance) begin
      if (branch_flag)    pc_d = branch_target;
      else if (br_pend_q) pc_d = br_target_q;
      else                pc_d = pc_q + 32'd4;
      br_pend_d = 1'b0;
    end else if (branch_flag) begin
      br_pend_d   = 1'b1;
      br_target_d = branch_target;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      inst_buf_q  <= 32'h0;
      br_target_q <= 32'h0;
      br_pend_q   <= 1'b0;
      cancel_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      inst_buf_q  <= inst_buf_d;
      br_target_q <= br_target_d;
      br_pend_q   <= br_pend_d;
      cancel_q    <= cancel_d;
    end
  end

  assign inst_req    = (state_q == S_REQ);
  assign inst_addr   = pc_q;
  assign if_pc       = pc_q;
  assign if_inst     = (state_q == S_DONE) ? inst_buf_q : 32'h0;
  assign stallreq_if = (state_q != S_DONE);

endmodule
